// File: rtl/irq_prio_ctrl.sv
// 68000 interrupt priority controller: synchronises up to seven active-low requests,
// latches them per source (level or falling edge), encodes IPL and answers IACK cycles.
module irq_prio_ctrl #(
  parameter int unsigned         NUM_SRC     = 7,
  parameter int unsigned         SYNC_STAGES = 2,
  parameter logic [NUM_SRC-1:0]  EDGE_MODE   = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_n,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               iack,
  input  logic [2:0]         iack_level,
  output logic [2:0]         ipl_n,
  output logic               avec_n,
  output logic               berr_n,
  output logic [NUM_SRC-1:0] pending
);

  localparam int unsigned LVL_W = 3;
  // Level 7 is non-maskable on the 68000, so only a full seven-source build forces it on.
  localparam logic [NUM_SRC-1:0] NMI_BIT =
    (NUM_SRC == 7) ? (NUM_SRC'(1) << (NUM_SRC - 1)) : '0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_END = 2'd2
  } state_e;

  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] s_c;
  logic [NUM_SRC-1:0] s_prev_q;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] pending_d;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] active_c;
  logic [NUM_SRC-1:0] hit_vec_c;
  logic [NUM_SRC-1:0] clr_c;
  logic               hit_c;
  logic [LVL_W-1:0]   lvl_c;
  logic [LVL_W-1:0]   ipl_q;
  logic               avec_q;
  logic               avec_d;
  logic               berr_q;
  logic               berr_d;
  logic               armed_q;
  state_e             state_q;
  state_e             state_d;

  // Input synchronisers; stored inverted so a cleared flop means "not requesting".
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= ~irq_n;
      for (int k = 1; k < int'(SYNC_STAGES); k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s_c = sync_q[SYNC_STAGES-1];

  // A fresh edge beats a same-cycle acknowledge clear.
  assign pending_d = (s_c & ~EDGE_MODE)
                   | (EDGE_MODE & ((pending_q & ~clr_c) | (s_c & ~s_prev_q)));

  always_ff @(posedge clk) begin
    if (reset) begin
      s_prev_q  <= '0;
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      s_prev_q  <= s_c;
      pending_q <= pending_d;
      if (mask_we) mask_q <= mask_wdata;
    end
  end

  assign active_c = pending_q & (mask_q | NMI_BIT);

  // Highest active index wins; later iterations overwrite lower ones.
  always_comb begin
    lvl_c = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (active_c[i]) lvl_c = LVL_W'(i + 1);
    end
  end

  // One-hot of the active source whose level matches the acknowledge.
  always_comb begin
    hit_vec_c = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (iack_level == LVL_W'(i + 1)) hit_vec_c[i] = active_c[i];
    end
  end

  assign hit_c = |hit_vec_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ipl_q   <= '1;
      avec_q  <= 1'b1;
      berr_q  <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ipl_q   <= ~lvl_c;
      avec_q  <= avec_d;
      berr_q  <= berr_d;
      armed_q <= armed_q | ~iack;
    end
  end

  // Acknowledge sequencing; armed_q keeps an IACK that straddles reset from re-triggering.
  always_comb begin
    state_d = state_q;
    avec_d  = avec_q;
    berr_d  = berr_q;
    clr_c   = '0;
    unique case (state_q)
      IDLE: begin
        if (iack && armed_q) begin
          state_d = ACK;
          avec_d  = ~hit_c;
          berr_d  = hit_c;
          clr_c   = hit_vec_c & EDGE_MODE;
        end
      end
      ACK, WAIT_END: begin
        if (iack) begin
          state_d = WAIT_END;
        end else begin
          state_d = IDLE;
          avec_d  = 1'b1;
          berr_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        avec_d  = 1'b1;
        berr_d  = 1'b1;
      end
    endcase
  end

  assign ipl_n   = ipl_q;
  assign avec_n  = avec_q;
  assign berr_n  = berr_q;
  assign pending = pending_q;

endmodule

// File: doc/irq_prio_ctrl.md
# irq_prio_ctrl

Parametrised 68000 interrupt controller that replaces the single-source IPL encoder in the glue CPLD. It takes up to seven active-low peripheral interrupt lines, synchronises them, and latches each in level or edge mode with per-source masking. It drives the encoded active-low IPL pins with the highest pending unmasked level. It also answers the CPU interrupt-acknowledge cycle with autovector (`avec_n`) or, for a spurious acknowledge, bus error (`berr_n`).

## Interface
- `NUM_SRC`, 7: number of sources, 1..7; source i has fixed priority level i+1.
- `SYNC_STAGES`, 2: flip-flop stages in each input synchroniser, ≥2.
- `EDGE_MODE`, all zeros: `NUM_SRC`-bit vector; bit i=1 makes source i falling-edge latched, 0 makes it level-sensitive.

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `irq_n` in `NUM_SRC`: asynchronous active-low interrupt requests.
- `mask_we` in 1: write strobe for the mask register.
- `mask_wdata` in `NUM_SRC`: new mask; 1 = enabled.
- `iack` in 1: high while the CPU runs an IACK cycle (FC=111 and AS decoded externally).
- `iack_level` in 3: level being acknowledged (CPU A3..A1); valid whenever `iack`=1.
- `ipl_n` out 3: encoded active-low interrupt priority for the CPU pins.
- `avec_n` out 1: active-low autovector request.
- `berr_n` out 1: active-low bus error for a spurious acknowledge.
- `pending` out `NUM_SRC`: raw pending state, before masking, for status reads.

## Operation
- **Synchroniser:** each `irq_n[i]` passes through `SYNC_STAGES` flops. `s[i]` is the synchronised line, inverted so that 1 = requesting.
- **Level sources:** `pending[i]` = `s[i]`, registered.
- **Edge sources:** `pending[i]` sets on a 0→1 transition of `s[i]`. It stays set until that source is acknowledged or `reset` is asserted. A new edge in the same cycle as the clear wins, so `pending[i]` stays 1.
- **Mask:** the mask register resets to all zeros. When `mask_we`=1, mask ← `mask_wdata`. Source 6 (level 7, NMI) ignores its mask bit when `NUM_SRC`=7.
- **Active set:** active = `pending` & effective mask.
- **Encoder:** `lvl` = (highest active index)+1, or 0 if nothing is active. `ipl_n` ← ~`lvl`, registered.
- **Acknowledge state machine**, states IDLE, ACK, WAIT_END:
  - IDLE: on the first cycle with `iack`=1, sample `iack_level`. If a source with level = `iack_level` is active, that is a hit; otherwise it is a miss. Go to ACK.
  - ACK: on a hit, assert `avec_n`=0 and, if that source is edge mode, clear its `pending` bit once. On a miss, assert `berr_n`=0. Go to WAIT_END.
  - WAIT_END: hold whichever of `avec_n` or `berr_n` was asserted while `iack`=1. When `iack`=0, release both outputs (back to 1) in that cycle's registered output, then go to IDLE.
  - `iack` dropping during ACK takes the same path: release, then IDLE.
- **Level-mode acknowledge:** a level source is never cleared by the acknowledge. The peripheral must drop its line itself.
- **Mask write during WAIT_END:** has no effect on the acknowledge already in progress.

## Timing
- **Reset values:** `ipl_n`=3'b111, `avec_n`=1, `berr_n`=1, `pending`=0, mask=0, state IDLE, all synchroniser flops cleared to 0 (requesting = inactive).
- **Request latency:** from `irq_n` falling to `ipl_n` changing is `SYNC_STAGES`+2 clocks (synchroniser, pending, encoder).
- **Mask latency:** from a `mask_we` cycle to `ipl_n` reflecting the new mask is 2 clocks.
- **Acknowledge latency:** `avec_n`/`berr_n` assert 1 clock after `iack` is first seen high. The edge-mode `pending` clear is visible in the same clock as the `avec_n` assertion; `ipl_n` updates 1 clock later.
- **Glitch-free output:** `ipl_n` is purely registered. It changes at most once per clock and never shows an intermediate code.
- **Reset mid-acknowledge:** `reset` wins. Strobes release the next clock, and the state machine ignores `iack` until it has been seen low once after reset.

## Test plan
- **Single level source:** `NUM_SRC`=7, mask=7'h10, hold `irq_n[4]`=0 → `ipl_n`=3'b010 after 4 clocks. Release it → `ipl_n` returns to 3'b111 after 4 clocks.
- **Priority:** mask=7'h7F, assert sources 1 and 5 → `ipl_n`=~3'd6. Drop source 5 → `ipl_n`=~3'd2.
- **Edge source acknowledge:** `EDGE_MODE`=7'h01, mask bit 0 set, pulse `irq_n[0]` low for 3 clocks → `ipl_n`=~3'd1 is held. Run `iack` with `iack_level`=1 → `avec_n`=0 one clock later, `pending[0]`=0, and `ipl_n`=3'b111 on the following clock.
- **Spurious acknowledge:** nothing pending, `iack`=1 with `iack_level`=3 → `berr_n`=0 from the next clock until `iack` falls; `avec_n` stays 1.
- **NMI and mask:** mask=0, assert `irq_n[6]` → `ipl_n`=3'b000. Assert `irq_n[2]` with mask=0 → `ipl_n` is unchanged.
- **Reset mid-acknowledge:** assert `reset` during WAIT_END → `avec_n`=1, `pending`=0, `ipl_n`=3'b111 on the next clock. With `iack` still high, no new strobe is issued.
